vram_arbiter: RTL

Shares one single-port synchronous video RAM between the 640x480 display scan and a drawing-engine write port. Sits between the VGA timing generator (consumes its `hcount`/`vcount`), the frame buffer RAM and the draw engine. Display reads own the RAM inside the active window. Draw writes are buffered in a small FIFO and drained only when the scan is outside the window. Produces a pixel stream at a fixed 3-cycle latency from the timing counters.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vram_arbiter_if.sv | 31 +++
 rtl/vram_wr_fifo.sv | 49 ++++
 rtl/vram_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg: 640x480 timing constants, pixel type and arbiter FSM state enum.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vga_pkg;

  localparam int H_START  = 144;
  localparam int V_START  = 35;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int PIXEL_W  = 4;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } vram_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_arbiter_if: draw-engine write port plus frame-buffer RAM port.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  wr_valid, wr_addr, wr_data, ram_rdata,
    output wr_ready, ram_addr, ram_we, ram_wdata
  );

  // Draw engine + RAM side
  modport master (
    output wr_valid, wr_addr, wr_data, ram_rdata,
    input  wr_ready, ram_addr, ram_we, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/vram_wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_wr_fifo: synchronous FIFO, DEPTH x WIDTH, wrap-bit pointers.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end
endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_arbiter: shares one VRAM between display scan reads (inside the       |
// | active window) and FIFO-buffered draw writes (drained outside it).         |
// | Optional: VRAM_ARB_STATS_EN adds wr_stall_cycles / wr_drop_count.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int H_START    = vga_pkg::H_START,
  parameter int V_START    = vga_pkg::V_START,
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = vga_pkg::PIXEL_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              vga_clock,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  vram_arbiter_if.slave     bus,
  output logic [DATA_W-1:0] pixel,
  output logic              frame_start
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       wr_stall_cycles,
  output logic [7:0]        wr_drop_count
`endif
);
  localparam int              FIFO_W    = ADDR_W + DATA_W;
  localparam logic [10:0]     H_LO      = 11'(H_START);
  localparam logic [10:0]     H_HI      = 11'(H_START + H_ACTIVE);
  localparam logic [10:0]     V_LO      = 11'(V_START);
  localparam logic [10:0]     V_HI      = 11'(V_START + V_ACTIVE);
  localparam logic [ADDR_W:0] PIX_COUNT = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

  vram_arb_state_t   r_state;
  vram_arb_state_t   w_next;
  logic              r_win_d2;
  logic              w_in_win;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_W-1:0] w_head;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_hit;
  logic [9:0]        w_hx;
  logic [9:0]        w_vy;
  logic [ADDR_W-1:0] w_x;
  logic [ADDR_W-1:0] w_y;
  logic [ADDR_W-1:0] w_row_base;
  logic [ADDR_W-1:0] w_scan_addr;

  assign w_in_win = ({1'b0, hcount} >= H_LO) && ({1'b0, hcount} < H_HI) &&
                    ({1'b0, vcount} >= V_LO) && ({1'b0, vcount} < V_HI);

  assign w_hx = hcount - 10'(H_START);
  assign w_vy = vcount - 10'(V_START);
  assign w_x  = ADDR_W'(w_hx);
  assign w_y  = ADDR_W'(w_vy);

  generate
    if (H_ACTIVE == 640) begin : g_shift_mul
      assign w_row_base = (w_y << 9) + (w_y << 7);
    end else begin : g_gen_mul
      assign w_row_base = w_y * ADDR_W'(H_ACTIVE);
    end
  endgenerate

  assign w_scan_addr = w_row_base + w_x;

  // Ready is held low through reset so no write is accepted into a flushing FIFO.
  assign bus.wr_ready = !w_full && !reset;
  assign w_push       = bus.wr_valid && bus.wr_ready;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (vga_clock),
    .rst       (reset),
    .push      (w_push),
    .push_data ({bus.wr_addr, bus.wr_data}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_head_addr = w_head[FIFO_W-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];
  assign w_head_hit  = ({1'b0, w_head_addr} < PIX_COUNT);

  // The decision is made on this cycle's inputs so an idle FIFO drains at t+2.
  always_comb begin
    w_next = IDLE;
    w_pop  = 1'b0;
    if (w_in_win) begin
      w_next = SCAN;
    end else if (!w_empty) begin
      w_next = DRAIN;
      w_pop  = 1'b1;
    end
  end

  always_ff @(posedge vga_clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // r_state==SCAN is the window flag delayed one cycle; r_win_d2 lines up with ram_rdata.
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      bus.ram_addr  <= '0;
      bus.ram_we    <= 1'b0;
      bus.ram_wdata <= '0;
      pixel         <= '0;
      frame_start   <= 1'b0;
      r_win_d2      <= 1'b0;
    end else begin
      r_win_d2    <= (r_state == SCAN);
      pixel       <= r_win_d2 ? bus.ram_rdata : '0;
      frame_start <= (hcount == '0) && (vcount == '0);
      bus.ram_we  <= 1'b0;
      unique case (w_next)
        SCAN: bus.ram_addr <= w_scan_addr;
        DRAIN: begin
          if (w_head_hit) begin
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= w_head_addr;
            bus.ram_wdata <= w_head_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic w_stall;
  logic w_drop;

  assign w_stall = bus.wr_valid && !bus.wr_ready;
  assign w_drop  = w_pop && !w_head_hit;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      wr_stall_cycles <= '0;
      wr_drop_count   <= '0;
    end else begin
      if (w_stall && (wr_stall_cycles != '1)) wr_stall_cycles <= wr_stall_cycles + 16'd1;
      if (w_drop && (wr_drop_count != '1))    wr_drop_count   <= wr_drop_count + 8'd1;
    end
  end
`endif
endmodule
`default_nettype wire
